wb_slave_regmem: RTL and testbench
==================================

# wb_slave_regmem

Wishbone classic-cycle slave: a small byte-lane-addressable register memory with per-word data tags, programmable wait states and error termination. Sits directly downstream of the Wishbone master on the shared bus. It consumes the master's single and block read/write cycles and terminates each one with ack_o or err_o, or with rty_o when configured. It is the default target for master bring-up and bus-cycle regression.

## Interface
- DATA_W, 32, data bus width.
- SEL_W, 4, byte selects; equals DATA_W/8.
- TAG_W, 4, data tag width.
- ADR_W, 32, address bus width (byte address).
- DEPTH, 16, number of words; power of two.
- WAIT_STATES, 1, idle cycles inserted between transfer accept and termination; range 0..7.
- BUSY_CYCLES, 2, post-write busy window in cycles; range 1..7.

- clk_i  in  1  rising-edge clock.
- rst_i  in  1  asynchronous, active-low reset.
- adr_i  in  ADR_W  byte address.
- dat_i  in  DATA_W  write data.
- sel_i  in  SEL_W  byte-lane enables.
- tgd_i  in  TAG_W  write data tag.
- we_i  in  1  1 = write, 0 = read.
- stb_i  in  1  strobe.
- cyc_i  in  1  bus cycle valid.
- dat_o  out  DATA_W  read data.
- tgd_o  out  TAG_W  read data tag.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry termination (WB_SLAVE_RTY_EN only; otherwise tied 0).

## Operation
- Storage: DEPTH × DATA_W data array plus DEPTH × TAG_W tag array. Word index = adr_i[log2(DEPTH)+1:2].
- Decode error:
  - err = (adr_i[1:0] != 0) or (adr_i >= DEPTH*4).
  - An erroring transfer never touches storage.
- FSM states: IDLE, WAIT, TERM, DONE.
  - IDLE: on cyc_i&stb_i, latch adr/we/sel/dat/tgd. Go to WAIT if WAIT_STATES>0, else TERM. Load the wait counter with WAIT_STATES-1.
  - WAIT: decrement the counter; go to TERM when it reaches 0.
  - TERM: exactly one of ack_o/err_o (or rty_o) is high for one cycle.
    - Write with ack: each lane with sel=1 takes its dat byte; the tag is written regardless of sel.
    - Read with ack: dat_o/tgd_o drive the stored word and tag.
    - Go to DONE.
  - DONE: one mandatory recovery cycle; stb_i is ignored. Then go to IDLE.
- Abort: cyc_i low in WAIT or TERM → IDLE next edge. No write, no termination is asserted.
- Outside TERM: dat_o=0, tgd_o=0, and all terminations are 0.
- Busy window: after a write ack, busy_cnt=BUSY_CYCLES counts down while in DONE/IDLE. A transfer accepted while busy_cnt≠0 is handled per Configuration.
- Block cycles: cyc_i may stay high across transfers. Each stb_i assertion seen in IDLE is an independent transfer.
- Storage content is unaffected by err or rty terminations.

## Timing
- Reset (rst_i=0, asynchronous): state IDLE; counters 0; all outputs 0; both arrays cleared to 0.
- Accept edge = edge T where IDLE samples cyc_i&stb_i=1.
- Termination is high during cycle T+1+WAIT_STATES.
- Minimum transfer period is WAIT_STATES+3 cycles.
- The master must hold adr/dat/sel/we stable until termination. The slave uses the latched copies regardless.
- Read data is registered and valid only while ack_o=1.
- Reset asserted mid-transfer: the termination is dropped immediately, and the arrays clear.

## Configuration
- WB_SLAVE_RTY_EN defined:
  - A transfer accepted while busy_cnt≠0 goes straight to TERM with rty_o=1, ignoring WAIT_STATES.
  - No storage access.
  - Decode errors take priority over retry.
- Undefined:
  - rty_o is tied 0.
  - A transfer accepted while busy stalls in WAIT until busy_cnt reaches 0, then completes normally after the usual WAIT_STATES.

## Test plan
- Reset, then single write 0xDEADBEEF with tag 0x7 to adr 0x8, sel=0xF, WAIT_STATES=1 → ack_o high exactly 2 cycles after accept. A subsequent read of 0x8 → dat_o=0xDEADBEEF, tgd_o=0x7 during ack.
- Partial write 0x11223344 to adr 0x8 with sel=0x5 over stored 0xDEADBEEF → read returns 0xDE22BE44.
- Read adr 0x40 (≥ DEPTH*4) and adr 0x6 (misaligned) → err_o for one cycle, ack_o=0. Storage unchanged.
- Block cycle, cyc_i held high: write 0x1 to 0x0 then 0x2 to 0x4, then read both → two acks per direction. Reads return 0x1 and 0x2. stb_i seen during DONE does not start a transfer.
- Write followed by read accepted 1 cycle after DONE (BUSY_CYCLES=2):
  - With WB_SLAVE_RTY_EN → rty_o pulse, no ack. Retried read acks with the correct data.
  - Without the macro → the read acks late (stalled), with the correct data.
- Drop cyc_i during WAIT of a write of 0xCAFEF00D (WAIT_STATES=3) → no termination pulses. The location retains its old value. The next transfer behaves normally.

Source files
------------

// File: rtl/wb_slave_regmem.sv
// Wishbone classic-cycle slave: DEPTH-word byte-lane register memory with data tags, wait states
// and error termination. Define WB_SLAVE_RTY_EN to answer accesses made during the busy window with rty_o.
//
// state | meaning
// IDLE  | waiting for cyc_i & stb_i; transfer fields latched on accept
// WAIT  | wait-state countdown, or stall until the post-write busy window closes
// TERM  | one-cycle ack_o / err_o / rty_o; writes commit at the end of this cycle
// DONE  | mandatory recovery cycle, stb_i ignored
module wb_slave_regmem #(
  parameter int DATA_W      = 32,
  parameter int SEL_W       = DATA_W / 8,
  parameter int TAG_W       = 4,
  parameter int ADR_W       = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int BUSY_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [TAG_W-1:0]  tgd_i,
  input  logic              we_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  output logic [DATA_W-1:0] dat_o,
  output logic [TAG_W-1:0]  tgd_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              rty_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [2:0] BUSY_LOAD = 3'(BUSY_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TERM, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [2:0]        busy_cnt_q;
  logic              stall_q, stall_d;
  logic              rty_q, rty_d;
  logic              err_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] dat_q;
  logic [TAG_W-1:0]  tgd_q;
  logic [DATA_W-1:0] rd_dat_q;
  logic [TAG_W-1:0]  rd_tgd_q;
  logic [DATA_W-1:0] mem_dat [DEPTH];
  logic [TAG_W-1:0]  mem_tgd [DEPTH];

  logic              accept, dec_err, busy, term, wr_commit, load_rd;
  logic [IDX_W-1:0]  adr_idx, rd_idx;

  assign adr_idx   = adr_i[IDX_W+1:2];
  assign dec_err   = (adr_i[1:0] != 2'b00) || (adr_i[ADR_W-1:IDX_W+2] != '0);
  assign busy      = (busy_cnt_q != 3'd0);
  assign accept    = (state_q == ST_IDLE) && cyc_i && stb_i;
  assign term      = (state_q == ST_TERM) && cyc_i;
  assign wr_commit = term && we_q && !err_q && !rty_q;
  assign load_rd   = (state_d == ST_TERM) && (state_q != ST_TERM);
  // zero-wait accepts go straight to TERM before the latched index exists
  assign rd_idx    = (state_q == ST_IDLE) ? adr_idx : idx_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_d    = stall_q;
    rty_d      = rty_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          wait_cnt_d = WAIT_LOAD;
          stall_d    = 1'b0;
          rty_d      = 1'b0;
`ifdef WB_SLAVE_RTY_EN
          if (busy && !dec_err) begin
            rty_d   = 1'b1;
            state_d = ST_TERM;
          end else begin
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_TERM;
          end
`else
          if (busy) begin
            stall_d = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_TERM;
          end
`endif
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          stall_d = 1'b0;
        end else if (stall_q) begin
          // the normal wait states start only once the busy window has closed
          if (!busy) begin
            stall_d    = 1'b0;
            wait_cnt_d = WAIT_LOAD;
            if (WAIT_STATES == 0) state_d = ST_TERM;
          end
        end else if (wait_cnt_q == 3'd0) begin
          state_d = ST_TERM;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      ST_TERM: state_d = cyc_i ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      rty_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      rty_q      <= rty_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      tgd_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      idx_q <= adr_idx;
      we_q  <= we_i;
      sel_q <= sel_i;
      dat_q <= dat_i;
      tgd_q <= tgd_i;
      err_q <= dec_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)             busy_cnt_q <= '0;
    else if (wr_commit)     busy_cnt_q <= BUSY_LOAD;
    else if (busy)          busy_cnt_q <= busy_cnt_q - 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_dat_q <= '0;
      rd_tgd_q <= '0;
    end else if (load_rd) begin
      rd_dat_q <= mem_dat[rd_idx];
      rd_tgd_q <= mem_tgd[rd_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_tgd[i] <= '0;
      end
    end else if (wr_commit) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (sel_q[b]) mem_dat[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
      mem_tgd[idx_q] <= tgd_q;
    end
  end

  assign ack_o = term && !err_q && !rty_q;
  assign err_o = term && err_q;
`ifdef WB_SLAVE_RTY_EN
  assign rty_o = term && rty_q;
`else
  assign rty_o = 1'b0;
`endif
  assign dat_o = (ack_o && !we_q) ? rd_dat_q : '0;
  assign tgd_o = (ack_o && !we_q) ? rd_tgd_q : '0;

endmodule

// File: tb/tb_wb_slave_regmem.sv
// Scoreboarded bench for wb_slave_regmem: the driver predicts each termination (kind, cycle, data)
// from a memory model and queues it; a negedge monitor compares whatever the slave presents.
module tb_wb_slave_regmem;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int TAG_W  = 4;
  localparam int ADR_W  = 32;
  localparam int DEPTH  = 16;
  localparam int WS     = 1;
  localparam int BUSY   = 2;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [ADR_W-1:0]  adr_i = '0;
  logic [DATA_W-1:0] dat_i = '0;
  logic [SEL_W-1:0]  sel_i = '0;
  logic [TAG_W-1:0]  tgd_i = '0;
  logic              we_i  = 1'b0;
  logic              stb_i = 1'b0;
  logic              cyc_i = 1'b0;
  logic [DATA_W-1:0] dat_o;
  logic [TAG_W-1:0]  tgd_o;
  logic              ack_o, err_o, rty_o;

  wb_slave_regmem #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .TAG_W(TAG_W), .ADR_W(ADR_W),
    .DEPTH(DEPTH), .WAIT_STATES(WS), .BUSY_CYCLES(BUSY)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .tgd_i(tgd_i), .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .dat_o(dat_o),
    .tgd_o(tgd_o), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o)
  );

  typedef struct {
    logic [2:0]  term;   // {rty, err, ack}
    logic [31:0] dat;
    logic [3:0]  tgd;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_dat [DEPTH];
  logic [3:0]  ref_tgd [DEPTH];
  int          cyc_n = 0;
  int          idle_edge = 0;
  int          busy_free = 0;
  int          tests = 0;
  int          fails = 0;

  initial forever #5 clk_i = ~clk_i;
  initial forever begin
    @(posedge clk_i);
    cyc_n++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: an accept is effectively deferred to the first edge after the busy window
  // (or answered with retry at once when that option is built in).
  task automatic predict(input int acc, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] t, output logic [2:0] kind);
    exp_t e;
    bit   err, bsy;
    int   idx;
    err = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    bsy = acc < busy_free;
    idx = int'(a[IDX_W+1:2]);
`ifdef WB_SLAVE_RTY_EN
    if (bsy && !err) begin
      kind  = 3'b100;
      e.cyc = acc;
    end else begin
      kind  = err ? 3'b010 : 3'b001;
      e.cyc = acc + WS;
    end
`else
    kind  = err ? 3'b010 : 3'b001;
    e.cyc = (bsy ? busy_free : acc) + WS;
`endif
    e.term = kind;
    e.dat  = '0;
    e.tgd  = '0;
    if (kind == 3'b001) begin
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) ref_dat[idx][8*b +: 8] = d[8*b +: 8];
        ref_tgd[idx] = t;
        busy_free = e.cyc + 2 + BUSY;
      end else begin
        e.dat = ref_dat[idx];
        e.tgd = ref_tgd[idx];
      end
    end
    idle_edge = e.cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic wait_term();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      got = ack_o | err_o | rty_o;
    end
    chk("term_seen", 64'(got), 64'd1);
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] t, input bit hold);
    logic [2:0] kind;
    for (int att = 0; att < 8; att++) begin
      adr_i = a; dat_i = d; sel_i = s; tgd_i = t; we_i = w;
      cyc_i = 1'b1; stb_i = 1'b1;
      predict(imax(cyc_n + 1, idle_edge), w, a, d, s, t, kind);
      wait_term();
      @(posedge clk_i); #1;
      stb_i = 1'b0;
      if (!hold) cyc_i = 1'b0;
      if (kind != 3'b100) break;
    end
  endtask

  task automatic idle(input int n);
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic abort_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [3:0] t);
    int acc;
    adr_i = a; dat_i = d; sel_i = s; tgd_i = t; we_i = 1'b1;
    cyc_i = 1'b1; stb_i = 1'b1;
    acc = imax(cyc_n + 1, idle_edge);
    for (int i = 0; i < 32 && cyc_n < acc; i++) begin
      @(posedge clk_i); #1;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    idle_edge = acc + 2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (ack_o || err_o || rty_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_term", {61'd0, rty_o, err_o, ack_o}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("term_kind", {61'd0, rty_o, err_o, ack_o}, {61'd0, e.term});
            chk("term_cycle", 64'(cyc_n), 64'(e.cyc));
            chk("rd_dat", 64'(dat_o), 64'(e.dat));
            chk("rd_tgd", 64'(tgd_o), 64'(e.tgd));
          end
        end else begin
          chk("idle_outputs", {28'd0, tgd_o, dat_o}, 64'd0);
        end
      end
    end
  end

  initial begin
    logic [2:0]  kind;
    logic [31:0] a;
    int          r;
    int          gap;

    for (int i = 0; i < DEPTH; i++) begin
      ref_dat[i] = '0;
      ref_tgd[i] = '0;
    end
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h8; dat_i = 32'hFFFF_FFFF; sel_i = 4'hF;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rty", 64'(rty_o), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    chk("rst_tgd", 64'(tgd_o), 64'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    xfer(1'b0, 32'h8, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 4'h7, 1'b0);
    idle(4);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b1, 32'h8, 32'h11223344, 4'h5, 4'h3, 1'b0);
    idle(4);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, 4'h0, 1'b0);

    xfer(1'b0, 32'h40, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b0, 32'h6, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b1, 32'h44, 32'hA5A5A5A5, 4'hF, 4'h9, 1'b0);
    xfer(1'b1, 32'hA, 32'h5A5A5A5A, 4'hF, 4'h9, 1'b0);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, 4'h0, 1'b0);

    idle(4);
    xfer(1'b1, 32'h0, 32'h1, 4'hF, 4'h1, 1'b1);
    xfer(1'b1, 32'h4, 32'h2, 4'hF, 4'h2, 1'b1);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, 4'h0, 1'b1);
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 4'h0, 1'b0);

    idle(4);
    xfer(1'b1, 32'hC, 32'h55AA_33CC, 4'hF, 4'hB, 1'b0);
    idle(1);
    xfer(1'b0, 32'hC, 32'h0, 4'hF, 4'h0, 1'b0);

    idle(4);
    xfer(1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 4'h2, 1'b0);
    idle(4);
    abort_write(32'h10, 32'hCAFEF00D, 4'hF, 4'h5);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b1, 32'h14, 32'h7777_8888, 4'hC, 4'h6, 1'b0);
    idle(3);
    xfer(1'b0, 32'h14, 32'h0, 4'hF, 4'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'($urandom_range(DEPTH * 4, 255));
      else             a = $urandom;
      gap = int'($urandom_range(0, 3));
      if (gap != 0) idle(gap);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    idle(4);
    xfer(1'b1, 32'h8, 32'h1357_9BDF, 4'hF, 4'hE, 1'b0);
    idle(4);
    adr_i = 32'h8; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
    predict(imax(cyc_n + 1, idle_edge), 1'b0, 32'h8, 32'h0, 4'hF, 4'h0, kind);
    wait_term();
    #1 rst_i = 1'b0;
    #1;
    chk("rst_mid_ack", 64'(ack_o), 64'd0);
    chk("rst_mid_dat", 64'(dat_o), 64'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ref_dat[i] = '0;
      ref_tgd[i] = '0;
    end
    idle_edge = 0;
    busy_free = 0;
    @(posedge clk_i); #1;
    xfer(1'b0, 32'h8, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, 4'h0, 1'b0);
    xfer(1'b0, 32'h3C, 32'h0, 4'hF, 4'h0, 1'b0);

    idle(5);
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
